// File: rtl/score_pkg.sv
// Shared definitions for the score video decoder: segment indices, digit
// patterns, FSM states, display window / cell / segment-region constants.
package score_pkg;

  // Segment bit positions inside a 7-bit pattern (bit 0 = a ... bit 6 = g)
  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_idx_e;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DECODE  = 2'd2,
    ST_PUBLISH = 2'd3
  } dec_state_e;

  // Digit patterns, bit order gfedcba
  localparam logic [6:0] PAT_BLANK = 7'h00;
  localparam logic [6:0] PAT_0     = 7'h3F;
  localparam logic [6:0] PAT_1     = 7'h06;
  localparam logic [6:0] PAT_2     = 7'h5B;
  localparam logic [6:0] PAT_3     = 7'h4F;
  localparam logic [6:0] PAT_4     = 7'h66;
  localparam logic [6:0] PAT_5     = 7'h6D;
  localparam logic [6:0] PAT_6     = 7'h7C;
  localparam logic [6:0] PAT_7     = 7'h07;
  localparam logic [6:0] PAT_8     = 7'h7F;
  localparam logic [6:0] PAT_9     = 7'h67;

  // Display window: VCNT 32..63 is exactly VCNT[7:5] == 3'b001
  localparam logic [7:0] WIN_V_FIRST = 8'd32;
  localparam logic [7:0] WIN_V_DONE  = 8'd64;
  localparam logic [2:0] WIN_V_TAG   = 3'b001;

  // Digit cells selected by HCNT[8:5] (32-pixel columns)
  localparam logic [3:0] CELL_P1_TENS  = 4'd4;   // H 128..159
  localparam logic [3:0] CELL_P1_UNITS = 4'd5;   // H 160..191
  localparam logic [3:0] CELL_P2_TENS  = 4'd10;  // H 320..351
  localparam logic [3:0] CELL_P2_UNITS = 4'd11;  // H 352..383

  // Cell-local segment region bounds
  localparam logic [4:0] REG_H_LEFT_LO  = 5'd16;
  localparam logic [4:0] REG_H_LEFT_HI  = 5'd19;
  localparam logic [4:0] REG_H_RIGHT_LO = 5'd28;
  localparam logic [4:0] REG_V_TOP_HI   = 5'd3;
  localparam logic [4:0] REG_V_MID_LO   = 5'd12;
  localparam logic [4:0] REG_V_UPPER_HI = 5'd15;
  localparam logic [4:0] REG_V_LOWER_LO = 5'd16;
  localparam logic [4:0] REG_V_BOT_LO   = 5'd28;

  // Segments whose region contains cell-local pixel (h, v); regions overlap
  function automatic logic [6:0] seg_hits(input logic [4:0] h, input logic [4:0] v);
    logic [6:0] m;
    logic       in_body;
    logic       left_col;
    logic       right_col;
    in_body   = (h >= REG_H_LEFT_LO);
    left_col  = in_body && (h <= REG_H_LEFT_HI);
    right_col = (h >= REG_H_RIGHT_LO);
    m         = 7'd0;
    m[SEG_A]  = in_body   && (v <= REG_V_TOP_HI);
    m[SEG_F]  = left_col  && (v <= REG_V_UPPER_HI);
    m[SEG_E]  = left_col  && (v >= REG_V_LOWER_LO);
    m[SEG_B]  = right_col && (v <= REG_V_UPPER_HI);
    m[SEG_C]  = right_col && (v >= REG_V_LOWER_LO);
    m[SEG_G]  = in_body   && (v >= REG_V_MID_LO) && (v <= REG_V_UPPER_HI);
    m[SEG_D]  = in_body   && (v >= REG_V_BOT_LO);
    return m;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Seven-segment pattern to digit lookup; tens cells accept only blank or "1".
module seg7_decode
  import score_pkg::*;
(
  input  logic [6:0] seg,
  input  logic       tens_mode,
  output logic [3:0] digit,
  output logic       valid
);

  // Pattern lookup; anything not listed is reported invalid
  always_comb begin
    digit = 4'd0;
    valid = 1'b0;
    if (tens_mode) begin
      case (seg)
        PAT_BLANK: begin digit = 4'd0; valid = 1'b1; end
        PAT_1:     begin digit = 4'd1; valid = 1'b1; end
        default:   begin digit = 4'd0; valid = 1'b0; end
      endcase
    end else begin
      case (seg)
        PAT_0:   begin digit = 4'd0; valid = 1'b1; end
        PAT_1:   begin digit = 4'd1; valid = 1'b1; end
        PAT_2:   begin digit = 4'd2; valid = 1'b1; end
        PAT_3:   begin digit = 4'd3; valid = 1'b1; end
        PAT_4:   begin digit = 4'd4; valid = 1'b1; end
        PAT_5:   begin digit = 4'd5; valid = 1'b1; end
        PAT_6:   begin digit = 4'd6; valid = 1'b1; end
        PAT_7:   begin digit = 4'd7; valid = 1'b1; end
        PAT_8:   begin digit = 4'd8; valid = 1'b1; end
        PAT_9:   begin digit = 4'd9; valid = 1'b1; end
        default: begin digit = 4'd0; valid = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/score_video_decoder.sv
// Recovers the two player scores from the rendered score video. Lit pixels
// are OR-ed into per-cell segment accumulators over one display window, the
// four digits are decoded, and a new pair only becomes stable after it has
// been seen on two consecutive valid frames.
module score_video_decoder
  import score_pkg::*;
(
  input  logic       CLK_DRV,
  input  logic       RST_N,
  input  logic [8:0] HCNT,
  input  logic [7:0] VCNT,
  input  logic       SCORE,
  output logic [4:0] P1_SCORE,
  output logic [4:0] P2_SCORE,
  output logic       FRAME_VALID,
  output logic       SCORE_CHG,
  output logic       DEC_ERR
);

  logic [8:0]      h_r;
  logic [7:0]      v_r;
  logic            score_r;
  dec_state_e      state_r;
  logic [3:0][6:0] acc_r;
  logic [4:0]      cand_p1_r;
  logic [4:0]      cand_p2_r;

  logic            in_win_s;
  logic            cell_en_s;
  logic [1:0]      cell_idx_s;
  logic [6:0]      pix_mask_s;
  logic [3:0][3:0] dig_s;
  logic [3:0]      dig_valid_s;
  logic [4:0]      p1_dec_s;
  logic [4:0]      p2_dec_s;

  // Input stage: counters and video are captured together so they stay aligned
  always_ff @(posedge CLK_DRV or negedge RST_N) begin
    if (!RST_N) begin
      h_r     <= 9'd0;
      v_r     <= 8'd0;
      score_r <= 1'b0;
    end else begin
      h_r     <= HCNT;
      v_r     <= VCNT;
      score_r <= SCORE;
    end
  end

  // Which digit cell the registered pixel falls in, and which segments it lights
  always_comb begin
    in_win_s   = (v_r[7:5] == WIN_V_TAG);
    cell_en_s  = 1'b0;
    cell_idx_s = 2'd0;
    case (h_r[8:5])
      CELL_P1_TENS:  begin cell_en_s = 1'b1; cell_idx_s = 2'd0; end
      CELL_P1_UNITS: begin cell_en_s = 1'b1; cell_idx_s = 2'd1; end
      CELL_P2_TENS:  begin cell_en_s = 1'b1; cell_idx_s = 2'd2; end
      CELL_P2_UNITS: begin cell_en_s = 1'b1; cell_idx_s = 2'd3; end
      default:       begin cell_en_s = 1'b0; cell_idx_s = 2'd0; end
    endcase
    if (in_win_s && cell_en_s && score_r) begin
      pix_mask_s = seg_hits(h_r[4:0], v_r[4:0]);
    end else begin
      pix_mask_s = 7'd0;
    end
  end

  // Cells 0 and 2 are tens digits, 1 and 3 are units digits
  for (genvar i = 0; i < 4; i++) begin : g_dec
    localparam logic TENS = ((i % 2) == 0) ? 1'b1 : 1'b0;
    seg7_decode u_seg7_decode (
      .seg       (acc_r[i]),
      .tens_mode (TENS),
      .digit     (dig_s[i]),
      .valid     (dig_valid_s[i])
    );
  end

  // Player scores as 10*tens + units (tens*8 + tens*2)
  always_comb begin
    p1_dec_s = ({1'b0, dig_s[0]} << 3'd3) + ({1'b0, dig_s[0]} << 3'd1) + {1'b0, dig_s[1]};
    p2_dec_s = ({1'b0, dig_s[2]} << 3'd3) + ({1'b0, dig_s[2]} << 3'd1) + {1'b0, dig_s[3]};
  end

  // Frame FSM: accumulate a full window, decode, then publish with pulses
  always_ff @(posedge CLK_DRV or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_WAIT;
      acc_r       <= '0;
      cand_p1_r   <= 5'd0;
      cand_p2_r   <= 5'd0;
      P1_SCORE    <= 5'd0;
      P2_SCORE    <= 5'd0;
      FRAME_VALID <= 1'b0;
      SCORE_CHG   <= 1'b0;
      DEC_ERR     <= 1'b0;
    end else begin
      FRAME_VALID <= 1'b0;
      SCORE_CHG   <= 1'b0;
      DEC_ERR     <= 1'b0;
      case (state_r)
        ST_WAIT: begin
          // Only a window entered on its first line is decoded; the first
          // pixel of that line is kept while the rest is cleared
          if (v_r == WIN_V_FIRST) begin
            state_r            <= ST_ACCUM;
            acc_r              <= '0;
            acc_r[cell_idx_s]  <= pix_mask_s;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_ACCUM: begin
          if (v_r == WIN_V_DONE) begin
            state_r <= ST_DECODE;
          end else if (!in_win_s) begin
            state_r <= ST_WAIT;
          end else begin
            acc_r[cell_idx_s] <= acc_r[cell_idx_s] | pix_mask_s;
          end
        end
        ST_DECODE: begin
          // Decision is registered here so the pulses appear during PUBLISH
          state_r <= ST_PUBLISH;
          if (!(&dig_valid_s)) begin
            DEC_ERR <= 1'b1;
          end else begin
            FRAME_VALID <= 1'b1;
            if ((p1_dec_s == cand_p1_r) && (p2_dec_s == cand_p2_r)) begin
              P1_SCORE  <= cand_p1_r;
              P2_SCORE  <= cand_p2_r;
              SCORE_CHG <= (cand_p1_r != P1_SCORE) || (cand_p2_r != P2_SCORE);
            end else begin
              cand_p1_r <= p1_dec_s;
              cand_p2_r <= p2_dec_s;
            end
          end
        end
        ST_PUBLISH: begin
          state_r <= ST_WAIT;
        end
        default: begin
          state_r <= ST_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_video_decoder.sv
// Self-checking bench for score_video_decoder: renders score frames pixel by
// pixel and compares pulses and stable scores against a behavioural model.
module tb_score_video_decoder;

  logic       clk_drv = 1'b0;
  logic       rst_n   = 1'b0;
  logic [8:0] hcnt    = 9'd0;
  logic [7:0] vcnt    = 8'd0;
  logic       score   = 1'b0;
  logic [4:0] p1_score;
  logic [4:0] p2_score;
  logic       frame_valid;
  logic       score_chg;
  logic       dec_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int stab_p1 = 0;
  int stab_p2 = 0;
  int cand_p1 = 0;
  int cand_p2 = 0;

  score_video_decoder dut (
    .CLK_DRV     (clk_drv),
    .RST_N       (rst_n),
    .HCNT        (hcnt),
    .VCNT        (vcnt),
    .SCORE       (score),
    .P1_SCORE    (p1_score),
    .P2_SCORE    (p2_score),
    .FRAME_VALID (frame_valid),
    .SCORE_CHG   (score_chg),
    .DEC_ERR     (dec_err)
  );

  always #5 clk_drv = ~clk_drv;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] units_pat(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7C;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h67;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int decode_units(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (units_pat(d) == s) return d;
    return -1;
  endfunction

  function automatic int decode_tens(input logic [6:0] s);
    if (s == 7'h00) return 0;
    if (s == 7'h06) return 1;
    return -1;
  endfunction

  // Segments (bit0=a .. bit6=g) whose region contains local pixel (h, v)
  function automatic logic [6:0] region_of(input int h, input int v);
    logic [6:0] m = 7'h00;
    if (h >= 16 && v <= 3)                      m[0] = 1'b1;
    if (h >= 28 && v <= 15)                     m[1] = 1'b1;
    if (h >= 28 && v >= 16)                     m[2] = 1'b1;
    if (h >= 16 && v >= 28)                     m[3] = 1'b1;
    if (h >= 16 && h <= 19 && v >= 16)          m[4] = 1'b1;
    if (h >= 16 && h <= 19 && v <= 15)          m[5] = 1'b1;
    if (h >= 16 && v >= 12 && v <= 15)          m[6] = 1'b1;
    return m;
  endfunction

  // Drawing rule: each lit segment uses pixels belonging to it alone
  function automatic bit draw_px(input logic [6:0] p, input int h, input int v);
    bit lit = 1'b0;
    if (p[0] && h >= 20 && h <= 27 && v <= 3)             lit = 1'b1;
    if (p[1] && h >= 28 && v >= 4 && v <= 11)             lit = 1'b1;
    if (p[2] && h >= 28 && v >= 16 && v <= 27)            lit = 1'b1;
    if (p[3] && h >= 20 && h <= 27 && v >= 28)            lit = 1'b1;
    if (p[4] && h >= 16 && h <= 19 && v >= 16 && v <= 27) lit = 1'b1;
    if (p[5] && h >= 16 && h <= 19 && v >= 4 && v <= 11)  lit = 1'b1;
    if (p[6] && h >= 20 && h <= 27 && v >= 12 && v <= 15) lit = 1'b1;
    return lit;
  endfunction

  function automatic logic [3:0][6:0] make_pats(input int p1, input int p2);
    logic [3:0][6:0] r;
    r[0] = (p1 >= 10) ? 7'h06 : 7'h00;
    r[1] = units_pat(p1 % 10);
    r[2] = (p2 >= 10) ? 7'h06 : 7'h00;
    r[3] = units_pat(p2 % 10);
    return r;
  endfunction

  task automatic step(input int h, input int v, input bit s);
    hcnt  = 9'(h);
    vcnt  = 8'(v);
    score = s;
    @(posedge clk_drv);
    #1;
  endtask

  // Render one frame; rst_at / jump_at (or -1) abort it at the given line
  task automatic run_frame(input string name, input logic [3:0][6:0] pat,
                           input bit noise, input int rst_at, input int jump_at);
    logic [3:0][6:0] macc = '0;
    bit ok = 1'b1;
    int base[4] = '{128, 160, 320, 352};
    logic [5:0] fv_m = '0, er_m = '0, ch_m = '0;
    logic [5:0] xfv = '0, xer = '0, xch = '0;
    int t1, u1, t2, u2, d1, d2;
    step(0, 31, 1'b0);
    step(0, 31, 1'b0);
    for (int v = 32; v < 64; v++) begin
      if (v == jump_at) begin
        ok = 1'b0;
        step(0, 100, 1'b0);
        step(0, 100, 1'b0);
        break;
      end
      if (v == rst_at) begin
        ok = 1'b0;
        rst_n = 1'b0;
        #2;
        check_eq({name, "/rst_p1"}, int'(p1_score), 0);
        check_eq({name, "/rst_p2"}, int'(p2_score), 0);
        stab_p1 = 0; stab_p2 = 0; cand_p1 = 0; cand_p2 = 0;
        rst_n = 1'b1;
      end
      for (int c = 0; c < 4; c++) begin
        for (int hl = 12; hl < 32; hl++) begin
          bit lit;
          lit = draw_px(pat[c], hl, v - 32)
                || (noise && $urandom_range(0, 47) == 0)
                || (hl < 16 && $urandom_range(0, 3) == 0);
          if (lit) macc[c] = macc[c] | region_of(hl, v - 32);
          step(base[c] + hl, v, lit);
        end
      end
      step(200, v, 1'b1);
    end
    hcnt = 9'd0; vcnt = 8'd64; score = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_drv);
      @(negedge clk_drv);
      fv_m[k] = frame_valid;
      er_m[k] = dec_err;
      ch_m[k] = score_chg;
    end
    step(0, 65, 1'b0);
    step(0, 65, 1'b0);
    if (ok) begin
      t1 = decode_tens(macc[0]); u1 = decode_units(macc[1]);
      t2 = decode_tens(macc[2]); u2 = decode_units(macc[3]);
      if (t1 < 0 || u1 < 0 || t2 < 0 || u2 < 0) begin
        xer = 6'b000100;
      end else begin
        xfv = 6'b000100;
        d1 = 10 * t1 + u1;
        d2 = 10 * t2 + u2;
        if (d1 == cand_p1 && d2 == cand_p2) begin
          if (cand_p1 != stab_p1 || cand_p2 != stab_p2) xch = 6'b000100;
          stab_p1 = cand_p1;
          stab_p2 = cand_p2;
        end else begin
          cand_p1 = d1;
          cand_p2 = d2;
        end
      end
    end
    check_eq({name, "/frame_valid"}, int'(fv_m), int'(xfv));
    check_eq({name, "/dec_err"},     int'(er_m), int'(xer));
    check_eq({name, "/score_chg"},   int'(ch_m), int'(xch));
    check_eq({name, "/p1"},          int'(p1_score), stab_p1);
    check_eq({name, "/p2"},          int'(p2_score), stab_p2);
  endtask

  initial begin
    logic [3:0][6:0] pat;
    int p1, p2, r;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_drv);
    #1;
    check_eq("reset/p1", int'(p1_score), 0);
    check_eq("reset/p2", int'(p2_score), 0);
    check_eq("reset/fv", int'(frame_valid), 0);
    check_eq("reset/chg", int'(score_chg), 0);
    check_eq("reset/err", int'(dec_err), 0);
    rst_n = 1'b1;
    step(0, 40, 1'b0);

    run_frame("f07_13_a", make_pats(7, 13), 1'b0, -1, -1);
    run_frame("f07_13_b", make_pats(7, 13), 1'b0, -1, -1);
    run_frame("f07_13_c", make_pats(7, 13), 1'b1, -1, -1);
    pat = make_pats(7, 13);
    pat[3] = 7'h17;
    run_frame("bad_abce", pat, 1'b0, -1, -1);
    run_frame("alt5", make_pats(5, 0), 1'b0, -1, -1);
    run_frame("alt6", make_pats(6, 0), 1'b0, -1, -1);
    run_frame("alt5b", make_pats(5, 0), 1'b0, -1, -1);
    run_frame("rst45", make_pats(7, 13), 1'b0, 45, -1);
    run_frame("post_a", make_pats(19, 8), 1'b0, -1, -1);
    run_frame("post_b", make_pats(19, 8), 1'b0, -1, -1);
    run_frame("jump", make_pats(3, 4), 1'b0, -1, 41);
    run_frame("blank", '0, 1'b0, -1, -1);

    p1 = 0; p2 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || $urandom_range(0, 2) == 0) begin
        p1 = $urandom_range(0, 19);
        p2 = $urandom_range(0, 19);
      end
      pat = make_pats(p1, p2);
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, 3);
        pat[r] = 7'($urandom());
      end
      run_frame($sformatf("rand%0d", i), pat, ($urandom_range(0, 3) == 0), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
